// File: rtl/corner_score_gen.sv
// corner_score_gen: streaming structure-tensor corner scorer.
// clk/en(async low reset); column stream in; sums, score, flag, centre coords out.

module corner_score_gen #(
   parameter int PATCH       = 5,
   parameter int PIX_W       = 8,
   parameter int ROW_W       = 8,
   parameter int COL_W       = 9,
   parameter int K_SHIFT     = 4,
   parameter int SCORE_SHIFT = 4,
   parameter int SCORE_W     = 16,
   localparam int ACC_W = 2*PIX_W + $clog2(PATCH*PATCH)
) (
   input  logic                       clk,
   input  logic                       en,
   input  logic                       in_valid,
   input  logic [(PATCH+2)*PIX_W-1:0] column_in,
   input  logic [ROW_W-1:0]           row_in,
   input  logic [COL_W-1:0]           col_in,
   input  logic                       mode,
   input  logic [SCORE_W-1:0]         thresh,
   output logic                       out_valid,
   output logic [ACC_W-1:0]           sxx,
   output logic [ACC_W-1:0]           syy,
   output logic signed [ACC_W:0]      sxy,
   output logic [SCORE_W-1:0]         score,
   output logic                       is_corner,
   output logic [ROW_W-1:0]           row_cnt,
   output logic [COL_W-1:0]           col_cnt
);

   localparam int D  = PATCH + 2;
   localparam int H  = PATCH / 2;
   localparam int PW = 2*PIX_W + 1;
   localparam int CW = PW + $clog2(PATCH);
   localparam int SW = ACC_W + 1;
   localparam int RW = 2*ACC_W + 3;
   localparam int NW = $clog2(D + 1);
   localparam int LV = $clog2(PATCH);

   localparam logic signed [RW-1:0] SMAX =
      $signed({{(RW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}});

   // v: column present, f: window full (real output)
   typedef struct packed {
      logic             v;
      logic             f;
      logic [ROW_W-1:0] r;
      logic [COL_W-1:0] c;
   } meta_t;

   meta_t k1, k2, k3, k4, k5, k6;
   logic  m1, m2, m3, m4, m5;

   // ---------------- stage 1: window ----------------
   // w0 newest column, w1 gradient column, w2 oldest
   // (only its interior rows are ever needed).
   logic [D*PIX_W-1:0]     w0, w1;
   logic [PATCH*PIX_W-1:0] w2;
   logic [NW-1:0]          fill, fill_nx;

   always_comb begin
      fill_nx = fill;
      if (col_in == '0)
         fill_nx = NW'(1);
      else if (fill != NW'(D))
         fill_nx = fill + NW'(1);
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         fill <= '0;
         w0   <= '0;
         w1   <= '0;
         w2   <= '0;
         k1   <= '0;
         m1   <= 1'b0;
      end else begin
         k1.v <= in_valid;
         if (in_valid) begin
            fill <= fill_nx;
            w0   <= column_in;
            w1   <= w0;
            w2   <= w1[(D-1)*PIX_W-1:PIX_W];
            k1.f <= (fill_nx == NW'(D));
            k1.r <= row_in - ROW_W'(H + 1);
            k1.c <= col_in - COL_W'(H + 1);
            m1   <= mode;
         end
      end
   end

   // ---------------- stage 2: gradients, products ----------------
   logic signed [PW-1:0] qxx_c [PATCH];
   logic signed [PW-1:0] qyy_c [PATCH];
   logic signed [PW-1:0] qxy_c [PATCH];
   logic signed [PW-1:0] qxx2  [PATCH];
   logic signed [PW-1:0] qyy2  [PATCH];
   logic signed [PW-1:0] qxy2  [PATCH];

   for (genvar g = 0; g < PATCH; g++) begin : g_grad
      logic [PIX_W-1:0]     pa, pb, pu, pd;
      logic signed [PW-1:0] gx, gy;
      assign pa = w0[(g+1)*PIX_W +: PIX_W];
      assign pb = w2[g*PIX_W +: PIX_W];
      assign pu = w1[(g+2)*PIX_W +: PIX_W];
      assign pd = w1[g*PIX_W +: PIX_W];
      assign gx = $signed({{(PW-PIX_W){1'b0}}, pa})
                - $signed({{(PW-PIX_W){1'b0}}, pb});
      assign gy = $signed({{(PW-PIX_W){1'b0}}, pu})
                - $signed({{(PW-PIX_W){1'b0}}, pd});
      assign qxx_c[g] = gx * gx;
      assign qyy_c[g] = gy * gy;
      assign qxy_c[g] = gx * gy;
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         for (int i = 0; i < PATCH; i++) begin
            qxx2[i] <= '0;
            qyy2[i] <= '0;
            qxy2[i] <= '0;
         end
         k2 <= '0;
         m2 <= 1'b0;
      end else begin
         for (int i = 0; i < PATCH; i++) begin
            qxx2[i] <= qxx_c[i];
            qyy2[i] <= qyy_c[i];
            qxy2[i] <= qxy_c[i];
         end
         k2 <= k1;
         m2 <= m1;
      end
   end

   // ---------------- stage 3: column sums, history ----------------
   logic signed [CW-1:0] csxx, csyy, csxy;
   logic signed [CW-1:0] hxx [PATCH];
   logic signed [CW-1:0] hyy [PATCH];
   logic signed [CW-1:0] hxy [PATCH];

   always_comb begin
      csxx = '0;
      csyy = '0;
      csxy = '0;
      for (int i = 0; i < PATCH; i++) begin
         csxx = csxx + CW'(qxx2[i]);
         csyy = csyy + CW'(qyy2[i]);
         csxy = csxy + CW'(qxy2[i]);
      end
   end

   // History moves for every column, full or not, so the
   // window stays aligned with the column stream.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         for (int i = 0; i < PATCH; i++) begin
            hxx[i] <= '0;
            hyy[i] <= '0;
            hxy[i] <= '0;
         end
         k3 <= '0;
         m3 <= 1'b0;
      end else begin
         if (k2.v) begin
            hxx[0] <= csxx;
            hyy[0] <= csyy;
            hxy[0] <= csxy;
            for (int i = 1; i < PATCH; i++) begin
               hxx[i] <= hxx[i-1];
               hyy[i] <= hyy[i-1];
               hxy[i] <= hxy[i-1];
            end
         end
         k3 <= k2;
         m3 <= m2;
      end
   end

   // ---------------- stage 4: window sums ----------------
   logic [ACC_W-1:0]     wxx, wyy, sxx4, syy4;
   logic signed [SW-1:0] wxy, sxy4;

   // Pairwise tree: level l folds element i+2^l into i.
   always_comb begin : g_tree
      logic [ACC_W-1:0]     tx [PATCH];
      logic [ACC_W-1:0]     ty [PATCH];
      logic signed [SW-1:0] tz [PATCH];
      for (int i = 0; i < PATCH; i++) begin
         tx[i] = ACC_W'(hxx[i]);
         ty[i] = ACC_W'(hyy[i]);
         tz[i] = SW'(hxy[i]);
      end
      for (int l = 0; l < LV; l++) begin
         for (int i = 0; i < PATCH; i++) begin
            if ((i % (2 << l)) == 0 && (i + (1 << l)) < PATCH) begin
               tx[i] = tx[i] + tx[i + (1 << l)];
               ty[i] = ty[i] + ty[i + (1 << l)];
               tz[i] = tz[i] + tz[i + (1 << l)];
            end
         end
      end
      wxx = tx[0];
      wyy = ty[0];
      wxy = tz[0];
   end

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         sxx4 <= '0;
         syy4 <= '0;
         sxy4 <= '0;
         k4   <= '0;
         m4   <= 1'b0;
      end else begin
         sxx4 <= wxx;
         syy4 <= wyy;
         sxy4 <= wxy;
         k4   <= k3;
         m4   <= m3;
      end
   end

   // ---------------- stage 5: det / trace^2 products ----------------
   logic signed [RW-1:0] xs, ys, xy, tr;
   logic signed [RW-1:0] det5, sq5, t25, tr5;
   logic [ACC_W-1:0]     sxx5, syy5;
   logic signed [SW-1:0] sxy5;

   assign xs = $signed({{(RW-ACC_W){1'b0}}, sxx4});
   assign ys = $signed({{(RW-ACC_W){1'b0}}, syy4});
   assign xy = $signed({{(RW-SW){sxy4[SW-1]}}, sxy4});
   assign tr = xs + ys;

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         det5 <= '0;
         sq5  <= '0;
         t25  <= '0;
         tr5  <= '0;
         sxx5 <= '0;
         syy5 <= '0;
         sxy5 <= '0;
         k5   <= '0;
         m5   <= 1'b0;
      end else begin
         det5 <= xs * ys;
         sq5  <= xy * xy;
         t25  <= (tr * tr) >>> K_SHIFT;
         tr5  <= tr;
         sxx5 <= sxx4;
         syy5 <= syy4;
         sxy5 <= sxy4;
         k5   <= k4;
         m5   <= m4;
      end
   end

   // ---------------- stage 6: raw score, then output ----------------
   logic signed [RW-1:0] raw6, sh;
   logic [ACC_W-1:0]     sxx6, syy6;
   logic signed [SW-1:0] sxy6;
   logic [SCORE_W-1:0]   sc;

   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         raw6 <= '0;
         sxx6 <= '0;
         syy6 <= '0;
         sxy6 <= '0;
         k6   <= '0;
      end else begin
         raw6 <= m5 ? (det5 - sq5 - t25) : tr5;
         sxx6 <= sxx5;
         syy6 <= syy5;
         sxy6 <= sxy5;
         k6   <= k5;
      end
   end

   assign sh = raw6 >>> SCORE_SHIFT;

   always_comb begin
      sc = '0;
      if (!raw6[RW-1]) begin
         if (sh > SMAX)
            sc = '1;
         else
            sc = sh[SCORE_W-1:0];
      end
   end

   // Data outputs hold between results; only out_valid pulses.
   always_ff @(posedge clk or negedge en) begin
      if (!en) begin
         out_valid <= 1'b0;
         sxx       <= '0;
         syy       <= '0;
         sxy       <= '0;
         score     <= '0;
         is_corner <= 1'b0;
         row_cnt   <= '0;
         col_cnt   <= '0;
      end else begin
         out_valid <= k6.v & k6.f;
         if (k6.v & k6.f) begin
            sxx       <= sxx6;
            syy       <= syy6;
            sxy       <= sxy6;
            score     <= sc;
            is_corner <= (sc >= thresh);
            row_cnt   <= k6.r;
            col_cnt   <= k6.c;
         end
      end
   end

endmodule

// File: tb/tb_corner_score_gen.sv
// tb_corner_score_gen: random and directed stimulus vs. image-level model.
// Expected results come from window sums computed directly over a test image.

module tb_corner_score_gen;

   localparam int PATCH   = 5;
   localparam int PIX_W   = 8;
   localparam int ROW_W   = 8;
   localparam int COL_W   = 9;
   localparam int SCORE_W = 16;
   localparam int ACC_W   = 2*PIX_W + $clog2(PATCH*PATCH);
   localparam int D       = PATCH + 2;
   localparam int NR      = 16;
   localparam int NC      = 128;

   logic                  clk;
   logic                  en;
   logic                  in_valid;
   logic [D*PIX_W-1:0]    column_in;
   logic [ROW_W-1:0]      row_in;
   logic [COL_W-1:0]      col_in;
   logic                  mode;
   logic [SCORE_W-1:0]    thresh;
   logic                  out_valid;
   logic [ACC_W-1:0]      sxx, syy;
   logic signed [ACC_W:0] sxy;
   logic [SCORE_W-1:0]    score;
   logic                  is_corner;
   logic [ROW_W-1:0]      row_cnt;
   logic [COL_W-1:0]      col_cnt;

   corner_score_gen #(
      .PATCH(PATCH), .PIX_W(PIX_W), .ROW_W(ROW_W), .COL_W(COL_W),
      .K_SHIFT(4), .SCORE_SHIFT(4), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk), .en(en), .in_valid(in_valid), .column_in(column_in),
      .row_in(row_in), .col_in(col_in), .mode(mode), .thresh(thresh),
      .out_valid(out_valid), .sxx(sxx), .syy(syy), .sxy(sxy),
      .score(score), .is_corner(is_corner),
      .row_cnt(row_cnt), .col_cnt(col_cnt)
   );

   typedef struct {
      int     cyc;
      longint sxx, syy, sxy, score;
      int     corner, row, col;
   } exp_t;

   exp_t   q[$];
   exp_t   me;
   int     img [NR][NC];
   int     cyc = 0;
   int     n_chk = 0;
   int     n_err = 0;
   int     fill = 0;
   int     thr = 1;
   int     n_out = 0;
   int     tgt_row = -1;
   int     tgt_col = -1;
   int     cap_hit = 0;
   longint cap_sxx, cap_syy, cap_sxy, cap_score, cap_cor;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, longint got, longint want);
      n_chk++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic exp_t model(int rc, int cc, int md);
      exp_t   e;
      longint gx, gy, raw;
      e.sxx = 0;
      e.syy = 0;
      e.sxy = 0;
      for (int r = rc - 2; r <= rc + 2; r++)
         for (int c = cc - 2; c <= cc + 2; c++) begin
            gx = img[r][c+1] - img[r][c-1];
            gy = img[r+1][c] - img[r-1][c];
            e.sxx += gx * gx;
            e.syy += gy * gy;
            e.sxy += gx * gy;
         end
      if (md != 0)
         raw = e.sxx * e.syy - e.sxy * e.sxy
             - (((e.sxx + e.syy) * (e.sxx + e.syy)) >>> 4);
      else
         raw = e.sxx + e.syy;
      if (raw < 0)
         e.score = 0;
      else begin
         e.score = raw >>> 4;
         if (e.score > 65535) e.score = 65535;
      end
      e.corner = (e.score >= thr) ? 1 : 0;
      e.cyc = 0;
      e.row = 0;
      e.col = 0;
      return e;
   endfunction

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic put_col(int row, int col, int md);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      row_in   = ROW_W'(row);
      col_in   = COL_W'(col);
      mode     = md[0];
      for (int s = 0; s < D; s++)
         column_in[s*PIX_W +: PIX_W] = 8'(img[row-D+1+s][col]);
      fill = (col == 0) ? 1 : ((fill < D) ? fill + 1 : D);
      if (fill == D) begin
         e = model(row - 3, col - 3, md);
         e.cyc = cyc + 7;
         e.row = (row - 3) & 255;
         e.col = (col - 3) & 511;
         q.push_back(e);
      end
   endtask

   // md: 0 trace, 1 Harris, 2 alternate per column
   task automatic run_line(int row, int len, int md, int gap_pct);
      int g;
      for (int c = 0; c < len; c++) begin
         g = ($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0;
         repeat (g) idle();
         put_col(row, c, (md == 2) ? (c % 2) : md);
      end
      idle();
   endtask

   task automatic drain();
      repeat (12) idle();
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic spec_line(string nm, int row, int len, int md, int tc,
                            longint ex, longint ey, longint ez,
                            longint esc, longint ecor);
      tgt_row = row - 3;
      tgt_col = tc;
      cap_hit = 0;
      run_line(row, len, md, 0);
      drain();
      chk({nm, "_hit"}, cap_hit, 1);
      chk({nm, "_sxx"}, cap_sxx, ex);
      chk({nm, "_syy"}, cap_syy, ey);
      chk({nm, "_sxy"}, cap_sxy, ez);
      chk({nm, "_score"}, cap_score, esc);
      chk({nm, "_corner"}, cap_cor, ecor);
      tgt_col = -1;
   endtask

   always @(negedge clk) begin
      if (en) begin
         if (out_valid) begin
            n_out++;
            if (q.size() == 0)
               chk("unexpected_valid", 1, 0);
            else begin
               me = q.pop_front();
               chk("latency", cyc, me.cyc);
               chk("sxx", longint'(sxx), me.sxx);
               chk("syy", longint'(syy), me.syy);
               chk("sxy", longint'(sxy), me.sxy);
               chk("score", longint'(score), me.score);
               chk("is_corner", is_corner, me.corner);
               chk("row_cnt", row_cnt, me.row);
               chk("col_cnt", col_cnt, me.col);
            end
            if (int'(col_cnt) == tgt_col && int'(row_cnt) == tgt_row) begin
               cap_hit   = 1;
               cap_sxx   = longint'(sxx);
               cap_syy   = longint'(syy);
               cap_sxy   = longint'(sxy);
               cap_score = longint'(score);
               cap_cor   = is_corner;
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("missing_valid", 0, 1);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      en        = 1'b0;
      in_valid  = 1'b0;
      column_in = '0;
      row_in    = '0;
      col_in    = '0;
      mode      = 1'b0;
      thr       = 1;
      thresh    = SCORE_W'(thr);
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_score", score, 0);
      chk("rst_corner", is_corner, 0);
      chk("rst_row", row_cnt, 0);
      chk("rst_col", col_cnt, 0);
      chk("rst_sxx", sxx, 0);
      en = 1'b1;

      // flat field
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) img[r][c] = 100;
      spec_line("flat_tr", 6, 12, 0, 3, 0, 0, 0, 0, 0);
      spec_line("flat_h", 6, 12, 1, 3, 0, 0, 0, 0, 0);

      // vertical step
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) img[r][c] = (c >= 4) ? 255 : 0;
      spec_line("step_tr", 6, 12, 0, 3, 650250, 0, 0, 40640, 1);
      spec_line("step_h", 6, 12, 1, 3, 650250, 0, 0, 0, 0);

      // ramp
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) img[r][c] = (10*c + 20*r) & 255;
      spec_line("ramp_tr", 6, 10, 0, 3, 10000, 40000, 20000, 3125, 1);
      spec_line("ramp_h", 6, 10, 1, 3, 10000, 40000, 20000, 0, 0);

      // isolated pixel
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) img[r][c] = 0;
      img[3][10] = 255;
      thr    = 1000;
      thresh = SCORE_W'(thr);
      spec_line("iso_tr", 6, 16, 0, 10, 130050, 130050, 0, 16256, 1);
      spec_line("iso_h", 6, 16, 1, 10, 130050, 130050, 0, 65535, 1);

      // random images, gaps, mode toggling, early line restart
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) img[r][c] = $urandom_range(0, 255);
      for (int t = 0; t < 6; t++) begin
         int row;
         thr    = $urandom_range(0, 3000);
         thresh = SCORE_W'(thr);
         row    = $urandom_range(6, NR - 1);
         if (t == 2) run_line(row, 4, 2, 30);
         run_line(row, $urandom_range(8, 40),
                  (t % 3 == 0) ? 2 : $urandom_range(0, 1), 30);
         drain();
      end

      // reset in the middle of a line
      for (int c = 0; c <= 100; c++) put_col(9, c, c % 2);
      chk("pre_rst_valid", out_valid, 1);
      #2 en = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_score", score, 0);
      chk("mid_rst_corner", is_corner, 0);
      chk("mid_rst_sxx", sxx, 0);
      chk("mid_rst_syy", syy, 0);
      chk("mid_rst_sxy", sxy, 0);
      chk("mid_rst_row", row_cnt, 0);
      chk("mid_rst_col", col_cnt, 0);
      q.delete();
      fill     = 0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      en    = 1'b1;
      n_out = 0;
      run_line(9, 20, 0, 0);
      drain();
      chk("post_rst_outs", n_out, 14);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
